tetris_gravity_ctrl: RTL
========================

TETRIS_GRAVITY_CTRL -- requirements
Module: tetris_gravity_ctrl

Interface
REQ-001 SHALL have parameters: CLK_KHZ, 50000, clock kHz; BASE_MS, 800, level-0 drop interval; STEP_MS, 50, decrement per level; MIN_MS, 50, interval floor.
REQ-002 SHALL have ports, one per line, clock and reset first:
  clk  in  1  clock
  reset_n  in  1  reset, asynchronous, active-low
  run  in  1  game active; high = gravity enabled
  pause  in  1  high = hold gravity, timer stopped
  level  in  4  requested game level
  level_valid  in  1  one-cycle strobe, sample level
  tmr_irq  in  1  timer timeout interrupt, level-sensitive
  tmr_address  out  3  timer register select
  tmr_chipselect  out  1  timer select
  tmr_write_n  out  1  timer write strobe, active-low
  tmr_writedata  out  16  timer write data
  drop_tick  out  1  one-cycle pulse per gravity interval
  cur_level  out  4  level currently programmed
  busy  out  1  high while any programming write sequence is in progress

Function
REQ-003 SHALL drive the timer as a single-cycle-write master: one write = exactly one cycle with tmr_chipselect=1, tmr_write_n=0, address/data valid; all other cycles tmr_chipselect=0, tmr_write_n=1, address=0, data=0.
REQ-004 SHALL use timer map: addr0 status (any write clears timeout), addr1 control (b0 ITO, b1 CONT, b2 START, b3 STOP), addr2 period[15:0], addr3 period[31:16].
REQ-005 SHALL compute period = max(BASE_MS - level*STEP_MS, MIN_MS) * CLK_KHZ - 1 in 32 bits; subtraction evaluated signed so an underflow yields MIN_MS.
REQ-006 SHALL implement states IDLE, W_STOP, W_CLR, W_PL, W_PH, W_START, RUN, W_ACK, W_PAUSE, PAUSED; each W_* state issues one write and lasts one cycle.
REQ-007 Program sequence SHALL be W_STOP (addr1=0x0008) -> W_CLR (addr0=0x0000) -> W_PL -> W_PH -> W_START (addr1=0x0007) -> RUN; busy=1 in W_STOP..W_START.
REQ-008 IDLE -> W_STOP when run=1 and pause=0; level used is last latched level (reset 0).
REQ-009 level_valid SHALL latch level into a pending register and set a pending flag, in any state; flag clears when W_STOP is entered, and cur_level updates to the latched value at W_PL.
REQ-010 In RUN, priority: run=0 -> W_STOP then IDLE (stop-only sequence: addr1=0x0008, no further writes); else pause=1 -> W_PAUSE; else pending flag -> W_STOP; else tmr_irq=1 -> W_ACK.
REQ-011 W_ACK SHALL write addr0=0x0000 and assert drop_tick in the same cycle, then return to RUN; irq is low the cycle after, so no double tick.
REQ-012 W_PAUSE SHALL write addr1=0x0008 -> PAUSED; PAUSED: run=0 -> IDLE; pause=0 and pending -> W_STOP; pause=0 otherwise -> W_START (resume without reload).
REQ-013 A timeout pending when a program sequence starts SHALL be discarded by W_CLR; no drop_tick for it.
REQ-014 level_valid arriving mid-sequence SHALL not alter the running sequence; pending triggers a fresh sequence on return to RUN.
REQ-015 run=0 seen in any W_* program state SHALL complete the current write, then go to W_STOP (stop-only) -> IDLE.
REQ-016 drop_tick SHALL never assert outside W_ACK; at most one per tmr_irq assertion.

Reset
REQ-017 On reset_n low, asynchronously: state IDLE, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, drop_tick=0, busy=0, cur_level=0, pending register=0, pending flag=0.
REQ-018 Reset mid-sequence SHALL abort with no further writes; after release, behaviour per REQ-008.

Verification
REQ-019 run=1, level 0 -> writes addr1=0x0008, addr0=0x0000, addr2=0x59FF, addr3=0x0262, addr1=0x0007, on 5 consecutive cycles; busy high 5 cycles.
REQ-020 RUN, level_valid with level=15 -> sequence with addr2=0x259F, addr3=0x0026; cur_level=15.
REQ-021 RUN, tmr_irq held high 3 cycles -> exactly one addr0=0x0000 write coincident with one drop_tick.
REQ-022 pause=1 in RUN -> addr1=0x0008; pause=0 -> single addr1=0x0007, no period writes; level=3 strobed while paused -> full sequence with addr2=0xE91F, addr3=0x01EF.
REQ-023 tmr_irq high during W_PL -> no drop_tick; W_CLR already cleared status; resumes in RUN.
REQ-024 reset_n low during W_PH -> outputs at reset values next cycle; no addr1 write until run re-sampled.

Source files
------------

// File: rtl/tetris_gravity_ctrl.sv
// rtl/tetris_gravity_ctrl.sv - gravity timer programming and drop-tick generation for a falling-block game
// Programs an external interval timer per game level and converts its timeouts into drop ticks.
module tetris_gravity_ctrl #(
  parameter int CLK_KHZ = 50000,
  parameter int BASE_MS = 800,
  parameter int STEP_MS = 50,
  parameter int MIN_MS  = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        pause,
  input  logic [3:0]  level,
  input  logic        level_valid,
  input  logic        tmr_irq,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  output logic        drop_tick,
  output logic [3:0]  cur_level,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, W_STOP, W_CLR, W_PL, W_PH, W_START, RUN, W_ACK, W_PAUSE, PAUSED
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_next_stop_only;
  logic               r_stop_only;
  logic [3:0]         r_pend_level;
  logic               r_pend;
  logic [3:0]         r_seq_level;
  logic [3:0]         r_cur_level;
  logic               r_irq_armed;
  logic [2:0]         r_address;
  logic               r_chipselect;
  logic               r_write_n;
  logic [15:0]        r_writedata;
  logic               r_drop_tick;
  logic               r_busy;
  logic signed [31:0] w_diff_ms;
  logic signed [31:0] w_ms;
  logic [31:0]        w_period;

  // Signed subtraction so high levels clamp to the floor instead of wrapping.
  assign w_diff_ms = BASE_MS - STEP_MS * $signed({28'd0, r_seq_level});
  assign w_ms      = (w_diff_ms < MIN_MS) ? MIN_MS : w_diff_ms;
  assign w_period  = w_ms * CLK_KHZ - 1;

  always_comb begin
    w_next           = r_state;
    w_next_stop_only = 1'b0;
    case (r_state)
      IDLE:    if (run && !pause) w_next = W_STOP;
      W_STOP: begin
        if (r_stop_only)  w_next = IDLE;
        else if (!run)    begin w_next = W_STOP; w_next_stop_only = 1'b1; end
        else              w_next = W_CLR;
      end
      W_CLR:   if (!run) begin w_next = W_STOP; w_next_stop_only = 1'b1; end else w_next = W_PL;
      W_PL:    if (!run) begin w_next = W_STOP; w_next_stop_only = 1'b1; end else w_next = W_PH;
      W_PH:    if (!run) begin w_next = W_STOP; w_next_stop_only = 1'b1; end else w_next = W_START;
      W_START: if (!run) begin w_next = W_STOP; w_next_stop_only = 1'b1; end else w_next = RUN;
      RUN: begin
        if (!run)                        begin w_next = W_STOP; w_next_stop_only = 1'b1; end
        else if (pause)                  w_next = W_PAUSE;
        else if (r_pend)                 w_next = W_STOP;
        else if (tmr_irq && r_irq_armed) w_next = W_ACK;
      end
      W_ACK:   w_next = RUN;
      W_PAUSE: w_next = PAUSED;
      PAUSED: begin
        if (!run)        w_next = IDLE;
        else if (!pause) w_next = r_pend ? W_STOP : W_START;
      end
      default: w_next = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so each write lines up with its W_* cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_stop_only  <= 1'b0;
      r_pend_level <= 4'd0;
      r_pend       <= 1'b0;
      r_seq_level  <= 4'd0;
      r_cur_level  <= 4'd0;
      r_irq_armed  <= 1'b1;
      r_address    <= 3'd0;
      r_chipselect <= 1'b0;
      r_write_n    <= 1'b1;
      r_writedata  <= 16'd0;
      r_drop_tick  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_stop_only <= w_next_stop_only;

      if (level_valid) begin
        r_pend_level <= level;
        r_pend       <= 1'b1;
      end else if (w_next == W_STOP) begin
        r_pend <= 1'b0;
      end
      if (w_next == W_STOP) r_seq_level <= r_pend_level;
      if (w_next == W_PL)   r_cur_level <= r_seq_level;

      // One tick per irq assertion: re-arm only once the line has been seen low.
      if (w_next == W_ACK) r_irq_armed <= 1'b0;
      else if (!tmr_irq)   r_irq_armed <= 1'b1;

      r_address    <= 3'd0;
      r_chipselect <= 1'b0;
      r_write_n    <= 1'b1;
      r_writedata  <= 16'd0;
      r_drop_tick  <= 1'b0;
      r_busy       <= (w_next == W_STOP) || (w_next == W_CLR) || (w_next == W_PL) ||
                      (w_next == W_PH) || (w_next == W_START);
      case (w_next)
        W_STOP, W_PAUSE: begin
          r_chipselect <= 1'b1; r_write_n <= 1'b0; r_address <= 3'd1; r_writedata <= 16'h0008;
        end
        W_CLR: begin
          r_chipselect <= 1'b1; r_write_n <= 1'b0; r_address <= 3'd0; r_writedata <= 16'h0000;
        end
        W_PL: begin
          r_chipselect <= 1'b1; r_write_n <= 1'b0; r_address <= 3'd2; r_writedata <= w_period[15:0];
        end
        W_PH: begin
          r_chipselect <= 1'b1; r_write_n <= 1'b0; r_address <= 3'd3; r_writedata <= w_period[31:16];
        end
        W_START: begin
          r_chipselect <= 1'b1; r_write_n <= 1'b0; r_address <= 3'd1; r_writedata <= 16'h0007;
        end
        W_ACK: begin
          r_chipselect <= 1'b1; r_write_n <= 1'b0; r_address <= 3'd0; r_writedata <= 16'h0000;
          r_drop_tick  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tmr_address    = r_address;
  assign tmr_chipselect = r_chipselect;
  assign tmr_write_n    = r_write_n;
  assign tmr_writedata  = r_writedata;
  assign drop_tick      = r_drop_tick;
  assign cur_level      = r_cur_level;
  assign busy           = r_busy;

endmodule
